// File: rtl/cpu_pkg.sv
// Shared CPU types: fetch entry layout, assembly states
// and opcode class constants.
package cpu_pkg;

  localparam int INSTR_BYTES = 3;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_BRA = 8'h20;
  localparam logic [7:0] OP_LDI = 8'h80;
  localparam logic [7:0] OP_ADD = 8'h90;

  typedef enum logic [1:0] {
    ASM_OP,
    ASM_B1,
    ASM_B2
  } asm_state_t;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Circular FIFO of assembled fetch entries.
// Flush wins over push and pop.
import cpu_pkg::*;

module instr_queue #(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t    slots [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_entry;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, byte streaming from program memory, 3-byte
// instruction assembly and decode queue with redirect flush.
import cpu_pkg::*;

module instr_fetch_unit #(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] RESET_PC = 8'h00,
  localparam int        CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_rd,
  output logic [7:0]    mem_addr,
  input  logic [7:0]    mem_rdata,
  input  logic          redirect,
  input  logic [7:0]    redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [7:0]    instr_op,
  output logic [7:0]    instr_b1,
  output logic [7:0]    instr_b2,
  output logic [7:0]    instr_pc,
  output logic [7:0]    fetch_pc,
  output logic [CW-1:0] occupancy
);

  asm_state_t   asm_q;
  asm_state_t   asm_d;
  logic [7:0]   pc_q;
  logic         inflight_q;
  logic [7:0]   inflight_pc_q;
  logic [7:0]   op_q;
  logic [7:0]   b1_q;
  logic [7:0]   op_pc_q;

  logic         issue;
  logic         accept;
  logic         push;
  logic         pop;
  logic         partial;
  logic [CW:0]  committed;
  logic [CW-1:0] q_count;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_head;
  fetch_entry_t new_entry;

  // An entry whose last byte is in flight already owns a slot.
  assign partial   = (asm_q == ASM_B2);
  assign committed = {1'b0, q_count} + (CW+1)'(partial);
  assign issue     = !reset && !redirect &&
                     (committed < (CW+1)'(DEPTH));
  assign accept    = inflight_q && !redirect;

  assign mem_rd    = issue;
  assign mem_addr  = issue ? pc_q : 8'h00;
  assign fetch_pc  = pc_q;

  assign instr_valid = !q_empty;
  assign pop         = instr_valid && instr_ready;
  assign instr_op    = q_head.op;
  assign instr_b1    = q_head.b1;
  assign instr_b2    = q_head.b2;
  assign instr_pc    = q_head.pc;
  assign occupancy   = q_count;

  assign new_entry = '{op: op_q, b1: b1_q,
                       b2: mem_rdata, pc: op_pc_q};

  always_comb begin
    asm_d = asm_q;
    push  = 1'b0;
    if (redirect) begin
      asm_d = ASM_OP;
    end else if (accept) begin
      unique case (asm_q)
        ASM_OP:  asm_d = ASM_B1;
        ASM_B1:  asm_d = ASM_B2;
        ASM_B2: begin
          asm_d = ASM_OP;
          push  = 1'b1;
        end
        default: asm_d = ASM_OP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_q <= ASM_OP;
    end else begin
      asm_q <= asm_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 8'h00;
      op_q          <= 8'h00;
      b1_q          <= 8'h00;
      op_pc_q       <= 8'h00;
    end else if (redirect) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + 8'h01;
        inflight_pc_q <= pc_q;
      end
      if (accept && asm_q == ASM_OP) begin
        op_q    <= mem_rdata;
        op_pc_q <= inflight_pc_q;
      end
      if (accept && asm_q == ASM_B1) begin
        b1_q <= mem_rdata;
      end
    end
  end

  instr_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_entry(new_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule
